spike_row_encoder: RTL and testbench
====================================

SPIKE_ROW_ENCODER -- requirements
Module: spike_row_encoder

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 32, number of array rows driven.
REQ-002 SHALL have parameter ACT_WIDTH, default 4, unsigned activation width per row.
REQ-003 SHALL have parameter NUM_STEPS, default 16, spike timesteps per frame (legal range >=1).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  activation frame offered.
REQ-007 SHALL have port in_ready  output  1  encoder can accept a frame.
REQ-008 SHALL have port in_act  input  NUM_ROWS*ACT_WIDTH  row r activation at bits [r*ACT_WIDTH +: ACT_WIDTH], unsigned.
REQ-009 SHALL have port out_row  output  NUM_ROWS  skewed spike bit per row, drives PE row spike input.
REQ-010 SHALL have port out_valid  output  NUM_ROWS  per-row qualifier for out_row, same skew.
REQ-011 SHALL have port done  output  1  single-cycle frame-complete pulse.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN; in_ready=1 only in IDLE.
REQ-013 SHALL accept a frame on a rising edge with in_valid=1 and in_ready=1 (accept edge A): capture all in_act, clear all row accumulators to 0, clear step counter, go IDLE->RUN.
REQ-014 SHALL ignore in_valid and in_act outside IDLE; captured activations stay stable for the frame.
REQ-015 SHALL, in RUN step t (0..NUM_STEPS-1, edge A+1+t), per row: sum = acc + act (ACT_WIDTH+1 bits); spike = sum[ACT_WIDTH]; acc <= sum[ACT_WIDTH-1:0].
REQ-016 SHALL leave RUN for DRAIN after edge A+NUM_STEPS; if NUM_ROWS=1, SHALL go directly to IDLE with done.
REQ-017 SHALL delay row r spike and valid by r extra registers: step t of row r is on out_row[r]/out_valid[r] after edge A+1+t+r, held one cycle.
REQ-018 SHALL drive out_row[r]=0 whenever out_valid[r]=0.
REQ-019 SHALL remain in DRAIN NUM_ROWS-1 cycles, then go to IDLE.
REQ-020 SHALL assert done for exactly one cycle, concurrent with the final out_valid[NUM_ROWS-1] (after edge A+NUM_STEPS+NUM_ROWS-1); in_ready SHALL be 1 from the next cycle.
REQ-021 SHALL give, per row over one frame, exactly floor(act*NUM_STEPS / 2^ACT_WIDTH) spikes; act=0 gives no spikes while out_valid still toggles.
REQ-022 SHALL size step/drain counters to clog2 of their range; no counter wrap within a frame.
REQ-023 SHALL make out_valid[r] high for exactly NUM_STEPS consecutive cycles per frame.

Reset
REQ-024 SHALL on rstn=0, asynchronously: state IDLE, in_ready=1 on release, out_row=0, out_valid=0, done=0, accumulators, counters, skew registers, captured activations =0.
REQ-025 SHALL abort any frame in progress on reset; no residual spikes or done after release.

Verification
REQ-026 Defaults, row0 act=1, others 0, accept at A -> out_row[0]=1 only after edge A+16; row1..31 never spike; done after edge A+47.
REQ-027 Row 5 act=8 -> out_row[5] spikes after edges A+1+t+5 for t=1,3,...,15 (8 spikes); out_valid[5] high edges A+6..A+21.
REQ-028 All rows act=15 -> 15 spikes per row, none at step 0; out_row[31] first spike after edge A+33.
REQ-029 in_valid held high through frame with changing in_act -> second frame accepted only at first edge after done, using in_act sampled there.
REQ-030 rstn pulsed low mid-RUN (step 7) -> outputs 0 immediately, in_ready=1 after release, no done, next frame behaves as REQ-026.
REQ-031 NUM_ROWS=1, NUM_STEPS=1, ACT_WIDTH=1, act=1 -> out_valid[0] one cycle after edge A+1 with out_row[0]=0, done same cycle.

Source files
------------

// File: rtl/spike_row_encoder_if.sv
// Handshake and output bundle for spike_row_encoder.
//   in_valid / in_ready : frame offer / accept handshake
//   in_act              : packed per-row activations, row r at [r*ACT_WIDTH +: ACT_WIDTH]
//   out_row / out_valid : skewed per-row spike bits and their qualifiers
//   done                : one-cycle frame-complete pulse
// master = frame source / spike consumer, slave = encoder.
interface spike_row_encoder_if #(
  parameter int NUM_ROWS  = 32,
  parameter int ACT_WIDTH = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NUM_ROWS*ACT_WIDTH-1:0] in_act;
  logic [NUM_ROWS-1:0]           out_row;
  logic [NUM_ROWS-1:0]           out_valid;
  logic                          done;

  modport master (
    output in_valid, in_act,
    input  in_ready, out_row, out_valid, done
  );

  modport slave (
    input  in_valid, in_act,
    output in_ready, out_row, out_valid, done
  );
endinterface

// File: rtl/spike_row_encoder.sv
// Rate-codes a frame of per-row activations into spike trains for a PE array.
// Each row accumulates its activation once per timestep; the carry out of the
// accumulator is that step's spike. Row r output is delayed r cycles so the
// spikes arrive as a diagonal wavefront across the array.
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : spike_row_encoder_if slave (in_valid/in_ready/in_act, out_row/out_valid/done)
//
// state | meaning
// IDLE  | waiting for a frame, in_ready=1
// RUN   | one accumulate step per cycle, NUM_STEPS cycles
// DRAIN | waiting NUM_ROWS-1 cycles for the skew chains to empty
module spike_row_encoder #(
  parameter int NUM_ROWS  = 32,
  parameter int ACT_WIDTH = 4,
  parameter int NUM_STEPS = 16
) (
  input logic                clk,
  input logic                rstn,
  spike_row_encoder_if.slave bus
);

  localparam int STEP_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int DRAIN_W = (NUM_ROWS > 2) ? $clog2(NUM_ROWS - 1) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NUM_STEPS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'((NUM_ROWS > 1) ? NUM_ROWS - 2 : 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                done_q, done_d;
  logic                accept;
  logic                run;
  logic [NUM_ROWS-1:0] out_row_w;
  logic [NUM_ROWS-1:0] out_valid_w;

  assign run = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          // A single row has no skew to drain, so the frame ends here.
          if (NUM_ROWS == 1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      step_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [ACT_WIDTH-1:0] act_q, act_d;
    logic [ACT_WIDTH-1:0] acc_q, acc_d;
    logic [ACT_WIDTH:0]   sum;
    // Bit 0 is the undelayed step result; bit r is what the row presents.
    logic [r:0]           sp_q, sp_d;
    logic [r:0]           vl_q, vl_d;

    assign sum = {1'b0, acc_q} + {1'b0, act_q};

    always_comb begin
      act_d = act_q;
      acc_d = acc_q;
      if (accept) begin
        act_d = bus.in_act[r*ACT_WIDTH +: ACT_WIDTH];
        acc_d = '0;
      end else if (run) begin
        acc_d = sum[ACT_WIDTH-1:0];
      end
      sp_d    = sp_q << 1;
      sp_d[0] = run & sum[ACT_WIDTH];
      vl_d    = vl_q << 1;
      vl_d[0] = run;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        act_q <= '0;
        acc_q <= '0;
        sp_q  <= '0;
        vl_q  <= '0;
      end else begin
        act_q <= act_d;
        acc_q <= acc_d;
        sp_q  <= sp_d;
        vl_q  <= vl_d;
      end
    end

    // A spike bit is only ever set alongside its valid bit, so out_row is
    // already zero whenever out_valid is low.
    assign out_row_w[r]   = sp_q[r];
    assign out_valid_w[r] = vl_q[r];
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_row   = out_row_w;
  assign bus.out_valid = out_valid_w;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_spike_row_encoder.sv
module tb_spike_row_encoder;
  localparam int NR = 32;
  localparam int AW = 4;
  localparam int NS = 16;

  typedef struct {
    int   cyc;
    logic spike;
  } ev_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   cyc  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spike_row_encoder_if #(.NUM_ROWS(NR), .ACT_WIDTH(AW)) bus ();
  spike_row_encoder #(.NUM_ROWS(NR), .ACT_WIDTH(AW), .NUM_STEPS(NS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  spike_row_encoder_if #(.NUM_ROWS(1), .ACT_WIDTH(1)) bus1 ();
  spike_row_encoder #(.NUM_ROWS(1), .ACT_WIDTH(1), .NUM_STEPS(1)) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  ev_t exp_q [NR][$];
  int  done_q[$];
  int  a_last = -1;
  int  e_last = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void push_frame(input int a, input logic [NR*AW-1:0] act);
    int val;
    ev_t e;
    a_last = a;
    e_last = a + NS + NR - 1;
    for (int r = 0; r < NR; r++) begin
      val = int'(act[r*AW +: AW]);
      for (int t = 0; t < NS; t++) begin
        e.cyc   = a + 1 + t + r;
        e.spike = (((val * (t + 1)) >> AW) - ((val * t) >> AW)) != 0;
        exp_q[r].push_back(e);
      end
    end
    done_q.push_back(e_last);
  endfunction

  function automatic int pending();
    int n = done_q.size();
    for (int r = 0; r < NR; r++) n += exp_q[r].size();
    return n;
  endfunction

  function automatic void flush_model();
    for (int r = 0; r < NR; r++) exp_q[r].delete();
    done_q.delete();
    a_last = -1;
    e_last = -1;
  endfunction

  logic [NR-1:0] ev_vec, er_vec;
  logic          ed, er_rdy;

  always @(negedge clk) begin
    if (rstn) begin
      ev_vec = '0;
      er_vec = '0;
      for (int r = 0; r < NR; r++) begin
        if (exp_q[r].size() != 0 && exp_q[r][0].cyc == cyc) begin
          ev_vec[r] = 1'b1;
          er_vec[r] = exp_q[r][0].spike;
          void'(exp_q[r].pop_front());
        end
      end
      ed = 1'b0;
      if (done_q.size() != 0 && done_q[0] == cyc) begin
        ed = 1'b1;
        void'(done_q.pop_front());
      end
      er_rdy = !(a_last >= 0 && cyc >= a_last && cyc < e_last);
      check("out_valid", 64'(bus.out_valid), 64'(ev_vec));
      check("out_row",   64'(bus.out_row),   64'(er_vec));
      check("done",      64'(bus.done),      64'(ed));
      check("in_ready",  64'(bus.in_ready),  64'(er_rdy));
      if (bus.in_valid && er_rdy) push_frame(cyc + 1, bus.in_act);
    end
  end

  task automatic send_frame(input logic [NR*AW-1:0] act);
    @(posedge clk); #1;
    bus.in_act   = act;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (e_last >= 0 && cyc <= e_last + 1 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", 64'(n), 64'(0));
    #1;
    check("model_drained", 64'(pending()), 64'(0));
  endtask

  function automatic logic [NR*AW-1:0] rand_act();
    logic [NR*AW-1:0] v;
    for (int i = 0; i < NR*AW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [NR*AW-1:0] act_v;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_act    = '0;
    bus1.in_valid = 1'b0;
    bus1.in_act   = '0;
    #1 rstn = 1'b0;
    #2;
    check("rst_out_row",   64'(bus.out_row),   64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_done",      64'(bus.done),      64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(1));
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // single slow row: one spike on row 0 at the last step
    act_v = '0;
    act_v[0 +: AW] = AW'(1);
    send_frame(act_v);
    wait_idle();

    // half-rate row 5
    act_v = '0;
    act_v[5*AW +: AW] = AW'(8);
    send_frame(act_v);
    wait_idle();

    // all rows at maximum activation
    act_v = '1;
    send_frame(act_v);
    wait_idle();

    // random frames
    for (int k = 0; k < 3; k++) begin
      send_frame(rand_act());
      wait_idle();
    end

    // in_valid held high with in_act changing every cycle
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 2*(NS+NR) + 4; k++) begin
      bus.in_act = rand_act();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_idle();

    // reset during step 7 of a frame
    send_frame(rand_act());
    while (cyc < a_last + 8) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_out_row",   64'(bus.out_row),   64'(0));
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_done",      64'(bus.done),      64'(0));
    check("abort_in_ready",  64'(bus.in_ready),  64'(1));
    flush_model();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (NS + NR + 4) @(posedge clk);
    act_v = '0;
    act_v[0 +: AW] = AW'(1);
    send_frame(act_v);
    wait_idle();

    // one row, one step, one-bit activation
    @(posedge clk); #1;
    bus1.in_act   = 1'b1;
    bus1.in_valid = 1'b1;
    @(negedge clk);
    check("s_ready_pre", 64'(bus1.in_ready), 64'(1));
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("s_valid_a",  64'(bus1.out_valid), 64'(0));
    check("s_done_a",   64'(bus1.done),      64'(0));
    check("s_ready_a",  64'(bus1.in_ready),  64'(0));
    @(negedge clk);
    check("s_valid_a1", 64'(bus1.out_valid), 64'(1));
    check("s_row_a1",   64'(bus1.out_row),   64'(0));
    check("s_done_a1",  64'(bus1.done),      64'(1));
    check("s_ready_a1", 64'(bus1.in_ready),  64'(1));
    @(negedge clk);
    check("s_valid_a2", 64'(bus1.out_valid), 64'(0));
    check("s_done_a2",  64'(bus1.done),      64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
